// File: rtl/approx_adder_rr_scheduler_if.sv
// Request/response bus of the shared approximate-adder scheduler.
// master = requester side, slave = scheduler side.
interface approx_adder_rr_scheduler_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [4*N_REQ-1:0] req_a;
  logic [4*N_REQ-1:0] req_b;
  logic               resp_valid;
  logic               resp_ready;
  logic [2:0]         resp_id;
  logic [4:0]         resp_sum;
  logic               resp_fallback;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sum, resp_fallback
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sum, resp_fallback
  );
endinterface

// File: rtl/approx_adder_rr_scheduler.sv
// Round-robin scheduler sharing one external combinational approximate
// 4-bit adder among N_REQ requesters. Each approximate sum is compared
// against an exact sum; results off by more than ET are replaced by the
// exact sum and counted in a saturating fallback counter.
module approx_adder_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int ET    = 6,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  approx_adder_rr_scheduler_if.slave  bus,
  output logic [3:0]                  add_a,
  output logic [3:0]                  add_b,
  input  logic [4:0]                  add_sum,
  input  logic                        cfg_force_exact,
  output logic [CNT_W-1:0]            fallback_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t     state;
  logic [2:0] rr_ptr;
  logic [2:0] winner;
  logic [2:0] next_ptr;
  logic       any_valid;
  logic [7:0] valid8;
  logic [7:0] grant8;
  logic [31:0] a32;
  logic [31:0] b32;

  logic [4:0] exact;
  logic [5:0] diff;
  logic [5:0] err;
  logic       fb;
  logic       cnt_full;

  // Zero-extend the packed request vectors so indexing uses exact widths.
  assign valid8 = 8'(bus.req_valid);
  assign a32    = 32'(bus.req_a);
  assign b32    = 32'(bus.req_b);

  // Rotating priority search: first valid requester starting at rr_ptr.
  always_comb begin
    logic [3:0] cand;
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    cand      = '0;
    winner    = '0;
    any_valid = 1'b0;
    // Walk the offsets downwards so the smallest offset wins last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + 4'(k);
      if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
      if (valid8[cand[2:0]]) begin
        winner    = cand[2:0];
        any_valid = 1'b1;
      end
    end
  end

  assign next_ptr = (winner == 3'(N_REQ - 1)) ? 3'd0 : winner + 3'd1;
  assign grant8   = 8'd1 << winner;

  // Grant strobe: one-hot to the winner, only while idle and out of reset.
  always_comb begin
    bus.req_ready = '0;
    if (rst_n && state == S_IDLE && any_valid) bus.req_ready = grant8[N_REQ-1:0];
  end

  // Error check of the shared adder's result against the exact sum.
  assign exact    = {1'b0, add_a} + {1'b0, add_b};
  assign diff     = {1'b0, add_sum} - {1'b0, exact};
  assign err      = diff[5] ? (6'd0 - diff) : diff;
  assign fb       = !cfg_force_exact && (err > 6'(ET));
  assign cnt_full = &fallback_cnt;

  // Control FSM with registered operands, response fields and counter.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      state             <= S_IDLE;
      rr_ptr            <= '0;
      add_a             <= '0;
      add_b             <= '0;
      bus.resp_valid    <= 1'b0;
      bus.resp_id       <= '0;
      bus.resp_sum      <= '0;
      bus.resp_fallback <= 1'b0;
      fallback_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            add_a       <= a32[{winner, 2'b00} +: 4];
            add_b       <= b32[{winner, 2'b00} +: 4];
            bus.resp_id <= winner;
            rr_ptr      <= next_ptr;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          bus.resp_sum      <= (cfg_force_exact || fb) ? exact : add_sum;
          bus.resp_fallback <= fb;
          if (fb && !cnt_full) fallback_cnt <= fallback_cnt + CNT_W'(1);
          bus.resp_valid    <= 1'b1;
          state             <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_adder_rr_scheduler.sv
// Self-checking bench for approx_adder_rr_scheduler: a transaction-level
// model checked every cycle, plus directed scenarios with literal results.
module tb_approx_adder_rr_scheduler;
  localparam int N_REQ = 4;
  localparam int ET    = 6;
  localparam int CNT_W = 3;   // small counter so saturation is reachable
  localparam int AW    = 4 * N_REQ;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  approx_adder_rr_scheduler_if #(.N_REQ(N_REQ)) bus ();
  logic [3:0]       add_a, add_b;
  logic [4:0]       add_sum;
  logic             cfg_force_exact;
  logic [CNT_W-1:0] fallback_cnt;

  // Bench-side approximate adder: exact + offset (mod 32), or a fixed value.
  int         adder_off;
  logic       use_fixed;
  logic [4:0] fixed_val;
  assign add_sum = use_fixed ? fixed_val : 5'(int'(add_a) + int'(add_b) + adder_off);

  approx_adder_rr_scheduler #(.N_REQ(N_REQ), .ET(ET), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus.slave),
    .add_a           (add_a),
    .add_b           (add_b),
    .add_sum         (add_sum),
    .cfg_force_exact (cfg_force_exact),
    .fallback_cnt    (fallback_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase 0 = waiting for a request, 1 = adder cycle, 2 = response offered
  int m_phase = 0, m_ptr = 0, m_a = 0, m_b = 0, m_id = 0, m_sum = 0, m_fb = 0, m_cnt = 0;
  bit started = 0;

  function automatic int pick();
    for (int k = 0; k < N_REQ; k++) begin
      int i;
      i = (m_ptr + k) % N_REQ;
      if (bus.req_valid[i] === 1'b1) return i;
    end
    return -1;
  endfunction

  // Compare on the falling edge, then advance the model to the next rising edge.
  always @(negedge clk) begin
    int w, exp_ready, approx, exact, err;
    if (started) begin
      w = pick();
      exp_ready = (rst_n && m_phase == 0 && w >= 0) ? (1 << w) : 0;
      check("m_req_ready", 32'(bus.req_ready), exp_ready);
      check("m_add_a", 32'(add_a), m_a);
      check("m_add_b", 32'(add_b), m_b);
      check("m_resp_valid", 32'(bus.resp_valid), (m_phase == 2) ? 1 : 0);
      check("m_fallback_cnt", 32'(fallback_cnt), m_cnt);
      if (m_phase == 2) begin
        check("m_resp_id", 32'(bus.resp_id), m_id);
        check("m_resp_sum", 32'(bus.resp_sum), m_sum);
        check("m_resp_fallback", 32'(bus.resp_fallback), m_fb);
      end
    end
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0; m_a = 0; m_b = 0; m_id = 0;
      m_sum = 0; m_fb = 0; m_cnt = 0;
      started = 1;
    end else if (m_phase == 0) begin
      w = pick();
      if (w >= 0) begin
        m_a = int'(bus.req_a[4*w +: 4]);
        m_b = int'(bus.req_b[4*w +: 4]);
        m_id = w;
        m_ptr = (w + 1) % N_REQ;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      exact  = m_a + m_b;
      approx = use_fixed ? int'(fixed_val) : (m_a + m_b + adder_off) % 32;
      err    = (approx > exact) ? approx - exact : exact - approx;
      if (cfg_force_exact) begin
        m_sum = exact; m_fb = 0;
      end else if (err > ET) begin
        m_sum = exact; m_fb = 1;
        if (m_cnt < CMAX) m_cnt++;
      end else begin
        m_sum = approx; m_fb = 0;
      end
      m_phase = 2;
    end else begin
      if (bus.resp_ready) m_phase = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One request from a single requester; returns the response fields.
  task automatic run_op(input int idx, input int a, input int b,
                        output int id, output int sum, output int fb);
    int k;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_a[4*idx +: 4] = 4'(a);
    bus.req_b[4*idx +: 4] = 4'(b);
    bus.req_valid = '0;
    bus.req_valid[idx] = 1'b1;
    @(negedge clk);
    k = 0;
    while (bus.req_ready === '0 && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("grant_onehot", 32'(bus.req_ready), 32'(1) << idx);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    k = 1;
    while (bus.resp_valid !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("resp_latency", k, 2);
    id  = int'(bus.resp_id);
    sum = int'(bus.resp_sum);
    fb  = int'(bus.resp_fallback);
    tick();
  endtask

  // ---------------- directed and random scenarios ----------------
  initial begin
    int id, sum, fb, k, ng;
    int g_idx[6];
    int g_cyc[6];
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    logic [2:0] h_id;
    logic [4:0] h_sum;
    logic       h_fb;

    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.resp_ready = 1'b1;
    cfg_force_exact = 1'b0; use_fixed = 1'b0; fixed_val = '0; adder_off = 0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_resp_sum", 32'(bus.resp_sum), 0);
    check("rst_add_a", 32'(add_a), 0);
    check("rst_cnt", 32'(fallback_cnt), 0);
    tick();

    // 1: exact adder, 3+4
    run_op(0, 3, 4, id, sum, fb);
    check("t1_id", id, 0); check("t1_sum", sum, 7); check("t1_fb", fb, 0);
    check("t1_cnt", 32'(fallback_cnt), 0);

    // 2: adder returns 0 for 15+15 -> error 30
    use_fixed = 1'b1; fixed_val = 5'd0;
    run_op(2, 15, 15, id, sum, fb);
    check("t2_id", id, 2); check("t2_sum", sum, 30); check("t2_fb", fb, 1);
    check("t2_cnt", 32'(fallback_cnt), 1);

    // 3: error exactly ET is kept, ET+1 falls back
    fixed_val = 5'd1;
    run_op(1, 3, 4, id, sum, fb);
    check("t3a_sum", sum, 1); check("t3a_fb", fb, 0);
    fixed_val = 5'd0;
    run_op(1, 3, 4, id, sum, fb);
    check("t3b_sum", sum, 7); check("t3b_fb", fb, 1);
    check("t3_cnt", 32'(fallback_cnt), 2);

    // forced exact with a bad adder: exact sum, counter untouched
    cfg_force_exact = 1'b1;
    run_op(3, 9, 9, id, sum, fb);
    check("fx_sum", sum, 18); check("fx_fb", fb, 0);
    check("fx_cnt", 32'(fallback_cnt), 2);
    cfg_force_exact = 1'b0;

    // counter saturation: six more fallbacks from 2 must stop at 7
    for (int i = 0; i < 6; i++) run_op(0, 8, 8, id, sum, fb);
    check("sat_fb", fb, 1);
    check("sat_cnt", 32'(fallback_cnt), CMAX);
    use_fixed = 1'b0;

    // 4: all requesters valid, round-robin order and spacing
    do_reset();
    bus.req_a = AW'($urandom); bus.req_b = AW'($urandom);
    bus.req_valid = '1;
    ng = 0;
    for (int c = 0; c < 24 && ng < 6; c++) begin
      @(negedge clk);
      if (bus.req_ready !== '0) begin
        for (int j = 0; j < N_REQ; j++) if (bus.req_ready[j] === 1'b1) g_idx[ng] = j;
        g_cyc[ng] = c;
        ng++;
      end
    end
    check("t4_grants", ng, 6);
    for (int i = 0; i < 6; i++) begin
      if (i < ng) begin
        check("t4_order", g_idx[i], exp_order[i]);
        if (i > 0) check("t4_spacing", g_cyc[i] - g_cyc[i-1], 3);
      end
    end
    tick();

    // 5: response stall with all requesters waiting
    do_reset();
    bus.resp_ready = 1'b0;
    bus.req_valid = '1;
    k = 0;
    @(negedge clk);
    while (bus.resp_valid !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("t5_resp_seen", 32'(bus.resp_valid), 1);
    h_id = bus.resp_id; h_sum = bus.resp_sum; h_fb = bus.resp_fallback;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_valid_held", 32'(bus.resp_valid), 1);
      check("t5_id_held", 32'(bus.resp_id), 32'(h_id));
      check("t5_sum_held", 32'(bus.resp_sum), 32'(h_sum));
      check("t5_fb_held", 32'(bus.resp_fallback), 32'(h_fb));
      check("t5_no_grant", 32'(bus.req_ready), 0);
    end
    tick();
    bus.resp_ready = 1'b1;
    tick();
    bus.req_valid = '0;
    for (int i = 0; i < 4; i++) tick();

    // 6a: reset during the adder cycle drops the transaction
    do_reset();
    bus.req_valid = 4'b0001; bus.req_a = 16'h0005; bus.req_b = 16'h0006;
    tick();                      // granted; now in the adder cycle
    rst_n = 1'b0; bus.req_valid = '0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6a_no_resp", 32'(bus.resp_valid), 0);
      check("t6a_add_a", 32'(add_a), 0);
      check("t6a_resp_sum", 32'(bus.resp_sum), 0);
    end
    tick();
    bus.req_valid = 4'b0011;     // pointer back at 0 -> requester 0 wins
    @(negedge clk);
    check("t6a_ptr", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = '0;
    for (int i = 0; i < 4; i++) tick();

    // 6b: reset while the response is offered
    do_reset();
    bus.resp_ready = 1'b0;
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    tick();
    tick();                      // response is being offered
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; bus.resp_ready = 1'b1;
    @(negedge clk);
    check("t6b_no_resp", 32'(bus.resp_valid), 0);
    check("t6b_resp_id", 32'(bus.resp_id), 0);
    tick();
    bus.req_valid = 4'b0011;
    @(negedge clk);
    check("t6b_ptr", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = '0;
    for (int i = 0; i < 4; i++) tick();

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst_n           = ($urandom_range(0, 79) != 0);
      bus.req_valid   = N_REQ'($urandom);
      bus.req_a       = AW'($urandom);
      bus.req_b       = AW'($urandom);
      bus.resp_ready  = ($urandom_range(0, 3) != 0);
      cfg_force_exact = ($urandom_range(0, 7) == 0);
      use_fixed       = ($urandom_range(0, 9) == 0);
      fixed_val       = 5'($urandom);
      case ($urandom_range(0, 3))
        0:       adder_off = 0;
        1:       adder_off = $urandom_range(5, 8);
        2:       adder_off = $urandom_range(24, 27);
        default: adder_off = $urandom_range(0, 31);
      endcase
      tick();
    end
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    bus.req_valid = '0;
    for (int i = 0; i < 5; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a hang anywhere above.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
